// File: rtl/key_schedule_sequencer.sv
// Iterative DES key schedule: one PC-1 / rotate / PC-2 datapath that emits
// the 16 round subkeys one per valid/ready handshake, in encrypt (K1..K16)
// or decrypt (K16..K1) order.

module permuted_choice_1 (
    input  logic [63:0] key,
    output logic [55:0] cd
);
    // DES bit n (1-based, MSB first) lives at key[64-n]
    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Parity bits (DES bits 8,16,...,64) are dropped by PC-1
    logic unused_parity;
    assign unused_parity = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};

    // Bit-select permutation of the key into C0/D0
    always_comb begin
        cd = '0;
        for (int unsigned i = 0; i < 56; i++) begin
            cd[6'(55 - i)] = key[6'(64 - PC1_TAB[i])];
        end
    end
endmodule

module permuted_choice_2 (
    input  logic [55:0] cd,
    output logic [47:0] subkey
);
    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // PC-2 discards CD bits 9,18,22,25,35,38,43,54
    logic unused_drop;
    assign unused_drop = ^{cd[47], cd[38], cd[34], cd[31],
                           cd[21], cd[18], cd[13], cd[2]};

    // Bit-select compression of C/D into the 48-bit subkey
    always_comb begin
        subkey = '0;
        for (int unsigned i = 0; i < 48; i++) begin
            subkey[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
        end
    end
endmodule

module key_schedule_sequencer #(
    parameter logic [15:0] SHIFT2_MASK = 16'h7EFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] key,
    input  logic        decrypt,
    input  logic        start,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic [55:0] cd, cd_n, pc1_cd;
    logic [47:0] pc2_key, subkey_n;
    logic        dir, dir_n;
    logic        valid_n, busy_n, done_n;
    logic [3:0]  round_n;
    logic        accept, handshake;

    function automatic logic [55:0] rotl(input logic [55:0] v, input logic two);
        logic [27:0] c, d;
        c = v[55:28];
        d = v[27:0];
        return two ? {c[25:0], c[27:26], d[25:0], d[27:26]}
                   : {c[26:0], c[27],    d[26:0], d[27]};
    endfunction

    function automatic logic [55:0] rotr(input logic [55:0] v, input logic two);
        logic [27:0] c, d;
        c = v[55:28];
        d = v[27:0];
        return two ? {c[1:0], c[27:2], d[1:0], d[27:2]}
                   : {c[0],   c[27:1], d[0],   d[27:1]};
    endfunction

    permuted_choice_1 u_pc1 (.key(key),  .cd(pc1_cd));
    permuted_choice_2 u_pc2 (.cd(cd_n),  .subkey(pc2_key));

    assign accept    = (state == IDLE) && start;
    assign handshake = (state == RUN) && subkey_ready;

    // Next C/D: kept apart from the FSM block so PC-2 sees the new halves
    // without forming a combinational loop through one process.
    always_comb begin
        cd_n  = cd;
        dir_n = dir;
        if (accept) begin
            dir_n = decrypt;
            cd_n  = decrypt ? pc1_cd : rotl(pc1_cd, SHIFT2_MASK[0]);
        end else if (handshake && round != 4'd15) begin
            cd_n = dir ? rotr(cd, SHIFT2_MASK[4'd15 - round])
                       : rotl(cd, SHIFT2_MASK[round + 4'd1]);
        end
    end

    // FSM next state and registered-output next values
    always_comb begin
        state_n  = state;
        subkey_n = subkey;
        valid_n  = subkey_valid;
        round_n  = round;
        busy_n   = busy;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = RUN;
                    subkey_n = pc2_key;
                    valid_n  = 1'b1;
                    round_n  = '0;
                    busy_n   = 1'b1;
                end
            end
            RUN: begin
                if (subkey_ready) begin
                    if (round == 4'd15) begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                        round_n = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        subkey_n = pc2_key;
                        round_n  = round + 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, C/D and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cd           <= '0;
            dir          <= 1'b0;
            subkey       <= '0;
            subkey_valid <= 1'b0;
            round        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            cd           <= cd_n;
            dir          <= dir_n;
            subkey       <= subkey_n;
            subkey_valid <= valid_n;
            round        <= round_n;
            busy         <= busy_n;
            done         <= done_n;
        end
    end
endmodule

// File: tb/tb_key_schedule_sequencer.sv
// Scoreboard bench for key_schedule_sequencer using the classic DES
// example key and its published subkeys K1..K16.

module tb_key_schedule_sequencer;
    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PAR = 64'h0101010101010101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] key = '0;
    logic        decrypt = 1'b0;
    logic        start = 1'b0;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready = 1'b1;
    logic [3:0]  round;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [3:0]  rnd;
        logic [47:0] sk;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [47:0] kenc [16];
    int          total = 0;
    int          bad = 0;
    int          hs_cnt = 0;
    bit          stall_en = 1'b0;
    int          stall_left = 0;
    logic        prev_stall = 1'b0;
    logic [47:0] prev_sk = '0;
    logic [3:0]  prev_rnd = '0;

    key_schedule_sequencer #(.SHIFT2_MASK(16'h7EFC)) dut (
        .clk(clk), .reset(reset), .key(key), .decrypt(decrypt), .start(start),
        .subkey(subkey), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
        .round(round), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumer ready: always high, or random stalls of 1-5 cycles
    always @(posedge clk) begin
        #1;
        if (!stall_en) begin
            subkey_ready = 1'b1;
        end else if (stall_left > 0) begin
            subkey_ready = 1'b0;
            stall_left--;
        end else begin
            subkey_ready = 1'b1;
            if ($urandom_range(0, 2) == 0) stall_left = $urandom_range(1, 5);
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks stall hold and done
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            hs_cnt = 0;
        end else begin
            if (prev_stall && subkey_valid) begin
                chk("hold_subkey", 64'(subkey), 64'(prev_sk));
                chk("hold_round", 64'(round), 64'(prev_rnd));
            end
            if (subkey_valid && subkey_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("subkey", 64'(subkey), 64'(mon_e.sk));
                    chk("round", 64'(round), 64'(mon_e.rnd));
                end
                hs_cnt++;
            end
            if (done) begin
                chk("handshakes_before_done", 64'(hs_cnt), 64'd16);
                chk("busy_at_done", 64'(busy), 64'd0);
                hs_cnt = 0;
            end
            prev_stall = subkey_valid && !subkey_ready;
            prev_sk    = subkey;
            prev_rnd   = round;
        end
    end

    task automatic push_sched(input logic dec);
        for (int r = 0; r < 16; r++) begin
            sb.push_back('{rnd: 4'(r), sk: (dec ? kenc[15 - r] : kenc[r])});
        end
    endtask

    // Issue start now (caller is at a negedge); optionally poke start in RUN
    task automatic run_sched(input logic [63:0] k, input logic dec,
                             input bit poke, input bit timed);
        int cyc = 0;
        bit got = 1'b0;
        key = k;
        decrypt = dec;
        start = 1'b1;
        push_sched(dec);
        while (!got && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            key = k;
            decrypt = dec;
            if (poke && (cyc == 4 || cyc == 16)) begin
                start = 1'b1;
                key = ~k;
                decrypt = ~dec;
            end
            @(negedge clk);
            if (cyc == 1) begin
                chk("valid_after_start", 64'(subkey_valid), 64'd1);
                chk("round0_after_start", 64'(round), 64'd0);
                chk("busy_after_start", 64'(busy), 64'd1);
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", 64'(got), 64'd1);
        if (timed) chk("done_latency", 64'(cyc), 64'd17);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit saw;
        kenc = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                 48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                 48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                 48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_subkey", 64'(subkey), 64'd0);
        chk("reset_valid", 64'(subkey_valid), 64'd0);
        chk("reset_round", 64'(round), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        chk("idle_ready_no_effect", 64'(subkey_valid), 64'd0);

        // Encrypt then decrypt, second start issued in the done cycle
        run_sched(KEY, 1'b0, 1'b0, 1'b1);
        run_sched(KEY, 1'b1, 1'b0, 1'b1);
        // start pulsed mid-RUN and on the final-handshake cycle
        run_sched(KEY, 1'b0, 1'b1, 1'b1);
        run_sched(KEY, 1'b1, 1'b1, 1'b1);
        // Random consumer stalls
        stall_en = 1'b1;
        run_sched(KEY, 1'b0, 1'b0, 1'b0);
        run_sched(KEY, 1'b1, 1'b0, 1'b0);
        stall_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Parity bits must not matter
        run_sched(KEY ^ PAR, 1'b0, 1'b0, 1'b1);
        run_sched(KEY ^ PAR, 1'b1, 1'b0, 1'b1);

        // Abort at round 7 with reset
        @(negedge clk);
        key = KEY;
        decrypt = 1'b0;
        start = 1'b1;
        push_sched(1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (subkey_valid && round == 4'd7) break;
        end
        chk("reached_round7", 64'(round), 64'd7);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        hs_cnt = 0;
        prev_stall = 1'b0;
        @(negedge clk);
        chk("abort_valid", 64'(subkey_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_subkey", 64'(subkey), 64'd0);
        chk("abort_round", 64'(round), 64'd0);
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        chk("no_done_after_abort", 64'(saw), 64'd0);
        run_sched(KEY, 1'b0, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
